pll_clk_manager: RTL
====================

# pll_clk_manager

Companion controller for the board PLL wrappers. It sits in the PLL output clock domain and synchronises and filters the PLL lock flag. It sequences a clean design reset after lock, detects and counts lock loss, and generates NUM_CH independently divided clock-enable strobes, so downstream logic runs on one clock with slower enables instead of extra PLL outputs.

## Interface
Parameters:
- NUM_CH, 2: number of clock-enable channels (1..8).
- DIV_W, 8: width of each channel divisor.
- DIVS, {8'd4, 8'd1}: packed divisors, channel i in bits [i*DIV_W +: DIV_W]; value 0 or 1 means always enabled.
- SYNC_STAGES, 2: flops in the pll_lock synchroniser (2..4).
- LOCK_FILTER, 8: consecutive synchronised-high cycles required to accept lock (1..255).
- RESET_CYCLES, 16: cycles sys_reset_n is held low after lock is accepted (1..65535).

Ports:
- clock_in  in  1  PLL output clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clock_in.
- run  in  1  enables divider counters and strobes.
- sys_reset_n  out  1  active-low design reset, registered.
- locked  out  1  high in RUN state.
- ce  out  NUM_CH  per-channel enable strobes, registered.
- lost_lock  out  1  one-cycle pulse on lock loss from RUN.
- lock_loss_count  out  8  saturating count of lock losses.

## Operation
- pll_lock passes through SYNC_STAGES flops to give lock_s. Synchroniser flops reset to 0.
- FSM states: WAIT_LOCK, HOLD, RUN. Reset enters WAIT_LOCK.
- WAIT_LOCK:
  - filt_cnt increments while lock_s=1 and clears to 0 on lock_s=0.
  - At the LOCK_FILTER-th consecutive high cycle, the FSM moves to HOLD and hold_cnt is cleared.
- HOLD:
  - hold_cnt increments each cycle.
  - lock_s=0 returns to WAIT_LOCK with filt_cnt=0; no loss is counted.
  - After RESET_CYCLES cycles in HOLD, the FSM moves to RUN.
- RUN:
  - sys_reset_n=1 and locked=1.
  - lock_s=0 moves to WAIT_LOCK. On that same edge sys_reset_n←0, locked←0, ce←0, and lost_lock←1 for one cycle.
- Divider channel i:
  - div_cnt[i] counts 0..DIVS_i−1 and wraps. It is cleared on RUN entry.
  - It advances only when in RUN and run=1.
  - ce[i]←1 when div_cnt[i]==DIVS_i−1 and run=1, otherwise 0.
  - DIVS_i ≤ 1: ce[i]=run in RUN.
- run=0 in RUN freezes all div_cnt and forces ce=0. Re-asserting run resumes counting from the frozen values.
- Outside RUN, ce=0 regardless of run.

## Timing
- Reset values: sys_reset_n=0, locked=0, ce=0, lost_lock=0, lock_loss_count=0, all counters 0.
- Reset assertion is asynchronous and takes effect immediately; reset_n low mid-RUN drops sys_reset_n with no lost_lock pulse.
- Lock-to-release latency: sys_reset_n rises exactly SYNC_STAGES+LOCK_FILTER+RESET_CYCLES clock_in edges after the first edge that samples pll_lock=1 (defaults: 26). This holds provided pll_lock stays high throughout.
- Lock-loss latency: sys_reset_n falls SYNC_STAGES+1 edges after the first edge sampling pll_lock=0.
- ce period: channel i pulses every DIVS_i enabled cycles. The first pulse comes on the DIVS_i-th cycle after RUN entry with run=1.
- A lock glitch shorter than LOCK_FILTER cycles (post-sync) in WAIT_LOCK restarts the filter.
- If lock_s falls on the same cycle HOLD would complete, the FSM returns to WAIT_LOCK and does not enter RUN.

## Configuration
- PLL_CLK_MANAGER_LOSS_COUNT_EN
  - Defined: lock_loss_count increments by 1 on each lost_lock pulse and saturates at 255.
  - Not defined: the counter register is removed and lock_loss_count is tied to 8'd0; lost_lock is unaffected.

## Test plan
- Defaults; reset_n released, pll_lock=1 from cycle 0, run=1 → sys_reset_n and locked rise on edge 26.
  - ce[0] high every cycle from RUN entry; ce[1] high on the 4th, 8th, 12th RUN cycles.
- pll_lock 5-cycle high pulse, low for 3 cycles, then steady high → no HOLD entry during the pulse; release occurs 26 edges after the steady rise.
- In RUN, drop pll_lock → sys_reset_n=0 and lost_lock single pulse 3 edges later; ce=0.
  - With the macro defined, lock_loss_count=1; after re-lock, sys_reset_n re-releases after 26 edges.
- Drop pll_lock for 1 cycle (post-sync) during HOLD → return to WAIT_LOCK, lost_lock stays 0, count unchanged.
- In RUN, run=0 for 3 cycles mid-period of channel 1 → ce=0 throughout, then the next ce[1] is delayed by exactly 3 cycles.
- Macro defined; 300 lock-loss events → lock_loss_count=255. Async reset_n pulse mid-RUN → all outputs return to reset values immediately.

Source files
------------

// File: rtl/pll_clk_manager.sv
// PLL lock synchroniser/filter, post-lock reset sequencer, lock-loss detector and per-channel clock-enable dividers.
// Optional macro PLL_CLK_MANAGER_LOSS_COUNT_EN keeps a saturating lock-loss counter; otherwise lock_loss_count is 0.
module pll_clk_manager #(
  parameter int                        NUM_CH       = 2,
  parameter int                        DIV_W        = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIVS         = {8'd4, 8'd1},
  parameter int                        SYNC_STAGES  = 2,
  parameter int                        LOCK_FILTER  = 8,
  parameter int                        RESET_CYCLES = 16
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              run,
  output logic              sys_reset_n,
  output logic              locked,
  output logic [NUM_CH-1:0] ce,
  output logic              lost_lock,
  output logic [7:0]        lock_loss_count
);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  localparam logic [7:0]  FILT_LAST = 8'(LOCK_FILTER - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RESET_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_filt_cnt;
  logic [15:0]            r_hold_cnt;
  logic                   r_sys_reset_n;
  logic                   r_locked;
  logic                   r_lost_lock;
  logic                   w_lock_s;
  logic                   w_run_entry;
  logic                   w_enable;
  logic                   w_loss;

  assign w_lock_s    = r_sync[SYNC_STAGES-1];
  assign w_run_entry = (r_state != RUN) && (w_next_state == RUN);
  assign w_enable    = (r_state == RUN) && (w_next_state == RUN) && run;
  assign w_loss      = (r_state == RUN) && !w_lock_s;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_LOCK;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A low lock_s always wins, so HOLD completing on the same cycle still falls back to WAIT_LOCK.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_LOCK: if (w_lock_s && (r_filt_cnt == FILT_LAST)) w_next_state = HOLD;
      HOLD: begin
        if (!w_lock_s) w_next_state = WAIT_LOCK;
        else if (r_hold_cnt == HOLD_LAST) w_next_state = RUN;
      end
      RUN:       if (!w_lock_s) w_next_state = WAIT_LOCK;
      default:   w_next_state = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_sys_reset_n <= 1'b0;
      r_locked      <= 1'b0;
      r_lost_lock   <= 1'b0;
    end else begin
      r_filt_cnt    <= (r_state == WAIT_LOCK && w_lock_s && w_next_state == WAIT_LOCK)
                       ? r_filt_cnt + 8'd1 : 8'd0;
      r_hold_cnt    <= (r_state == HOLD && w_next_state == HOLD) ? r_hold_cnt + 16'd1 : 16'd0;
      r_sys_reset_n <= (w_next_state == RUN);
      r_locked      <= (w_next_state == RUN);
      r_lost_lock   <= w_loss;
    end
  end

  assign sys_reset_n = r_sys_reset_n;
  assign locked      = r_locked;
  assign lost_lock   = r_lost_lock;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_I = DIVS[i*DIV_W +: DIV_W];

    logic r_ce;

    if (DIV_I <= DIV_W'(1)) begin : g_bypass
      always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
          r_ce <= 1'b0;
        end else begin
          r_ce <= w_enable;
        end
      end
    end else begin : g_div
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_I - DIV_W'(1);

      logic [DIV_W-1:0] r_div_cnt;

      // Counter holds its value while run is low so a pause simply stretches the period.
      always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
          r_div_cnt <= '0;
          r_ce      <= 1'b0;
        end else if (w_run_entry) begin
          r_div_cnt <= '0;
          r_ce      <= 1'b0;
        end else if (w_enable) begin
          r_ce      <= (r_div_cnt == DIV_LAST);
          r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end else begin
          r_ce      <= 1'b0;
        end
      end
    end

    assign ce[i] = r_ce;
  end

`ifdef PLL_CLK_MANAGER_LOSS_COUNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_count = r_loss_cnt;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule
